// File: rtl/ifetch_seq_if.sv
// Fetch/issue bus of the instruction sequencer.
// The master side is the sequencer: it requests instruction words from
// instruction memory and presents the latched word to the downstream stage.
interface ifetch_seq_if;
    // Instruction-memory side.
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_rdata;

    // Downstream issue side.
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [1:0]  op_ext;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc_plus2;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata,
        output instr,
        output opcode,
        output op_ext,
        output instr_valid,
        input  instr_ready,
        output pc_plus2
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata,
        input  instr,
        input  opcode,
        input  op_ext,
        input  instr_valid,
        output instr_ready,
        input  pc_plus2
    );
endinterface

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer.
// Fetches one 16-bit word at the current PC, holds it for the downstream
// stage until it is accepted, then advances the PC sequentially or to a
// branch/jump target resolved from the decoder flags and rs_data. A halt
// instruction parks the sequencer until reset.
module ifetch_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    ifetch_seq_if.master       bus,
    input  logic               halt,
    input  logic               jump,
    input  logic               beqz,
    input  logic               bnez,
    input  logic               bgez,
    input  logic               bltz,
    input  logic               sel_pc_opA,
    input  logic               sel_pc_opB,
    input  logic [15:0]        rs_data,
    output logic               halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;

    logic [15:0] pc_inc;
    logic [15:0] imm8_sext;
    logic [15:0] imm11_sext;
    logic [15:0] target_base;
    logic [15:0] target_off;
    logic [15:0] target;
    logic        rs_zero;
    logic        rs_neg;
    logic        taken;

    // Sequential PC and the offsets carried in the held instruction word.
    // All arithmetic is 16 bits wide, so it wraps at the top of the space.
    assign pc_inc     = pc_q + 16'd2;
    assign imm8_sext  = {{8{instr_q[7]}}, instr_q[7:0]};
    assign imm11_sext = {{5{instr_q[10]}}, instr_q[10:0]};

    // Branch target: register- or PC-relative base plus a short or long offset.
    assign target_base = sel_pc_opA ? rs_data : pc_inc;
    assign target_off  = sel_pc_opB ? imm8_sext : imm11_sext;
    assign target      = target_base + target_off;

    // Branch condition; several flags at once simply OR together.
    assign rs_zero = (rs_data == 16'h0000);
    assign rs_neg  = rs_data[15];
    assign taken   = jump
                   | (beqz &  rs_zero)
                   | (bnez & ~rs_zero)
                   | (bltz &  rs_neg)
                   | (bgez & ~rs_neg);

    // Issued instruction and its decoder fields come straight from the
    // held word, so they stay stable for the whole issue phase.
    assign bus.instr     = instr_q;
    assign bus.opcode    = instr_q[15:11];
    assign bus.op_ext    = instr_q[1:0];
    assign bus.imem_addr = pc_q;
    assign bus.pc_plus2  = pc_inc;

    // State, PC and instruction registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of order.
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state, next-PC and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        halted          = 1'b0;

        case (state_q)
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_rdy) begin
                    instr_d = bus.imem_rdata;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) begin
                    if (halt) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = taken ? target : pc_inc;
                        state_d = FETCH;
                    end
                end
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // While reset is held nothing is requested or offered downstream.
        if (rst) begin
            bus.imem_req    = 1'b0;
            bus.instr_valid = 1'b0;
            halted          = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: a driver plays instruction memory and
// the downstream stage, pushing expected fetch addresses and issued words
// into queues; a monitor pops and compares them on the opposite clock edge.
module tb_ifetch_seq;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_seq_if bus();

    logic        halt, jump, beqz, bnez, bgez, bltz, sel_pc_opA, sel_pc_opB;
    logic [15:0] rs_data;
    logic        halted;

    ifetch_seq #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .halt       (halt),
        .jump       (jump),
        .beqz       (beqz),
        .bnez       (bnez),
        .bgez       (bgez),
        .bltz       (bltz),
        .sel_pc_opA (sel_pc_opA),
        .sel_pc_opB (sel_pc_opB),
        .rs_data    (rs_data),
        .halted     (halted)
    );

    typedef struct {
        logic [15:0] word;
        logic [15:0] rs;
        bit halt, jump, beqz, bnez, bgez, bltz, opa, opb;
        int wf;     // cycles imem_rdy stays low
        int wi;     // cycles instr_ready stays low
        int abort;  // 0 none, 1 reset during fetch, 2 reset during issue
    } txn_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
    } issue_exp_t;

    logic [15:0] fetch_q[$];
    issue_exp_t  issue_q[$];

    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_pc;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference next-PC, straight from the branch rules using integer arithmetic.
    function automatic logic [15:0] model_next(input logic [15:0] pc, input txn_t t);
        bit taken;
        int base, off, res;
        taken = t.jump
             || (t.beqz && t.rs == 16'h0000)
             || (t.bnez && t.rs != 16'h0000)
             || (t.bltz && t.rs >= 16'h8000)
             || (t.bgez && t.rs <  16'h8000);
        if (!taken) begin
            res = (int'(pc) + 2) % 65536;
        end else begin
            base = t.opa ? int'(t.rs) : int'(pc) + 2;
            if (t.opb) begin
                off = int'(t.word) % 256;
                if (off >= 128) off -= 256;
            end else begin
                off = int'(t.word) % 2048;
                if (off >= 1024) off -= 2048;
            end
            res = (base + off + 131072) % 65536;
        end
        return 16'(res);
    endfunction

    function automatic txn_t plain_txn();
        txn_t t;
        t.word = 16'($urandom);
        t.rs   = 16'($urandom);
        t.halt = 0; t.jump = 0; t.beqz = 0; t.bnez = 0;
        t.bgez = 0; t.bltz = 0; t.opa = 0; t.opb = 0;
        t.wf = 0; t.wi = 0; t.abort = 0;
        return t;
    endfunction

    function automatic txn_t jump_txn(input logic [15:0] dest);
        txn_t t;
        t = plain_txn();
        t.word = 16'($urandom) & 16'hFF00;
        t.jump = 1; t.opa = 1; t.opb = 1;
        t.rs   = dest;
        return t;
    endfunction

    task automatic drive_random_flags();
        {halt, jump, beqz, bnez, bgez, bltz, sel_pc_opA, sel_pc_opB} = 8'($urandom);
        rs_data = 16'($urandom);
    endtask

    task automatic drive_flags(input txn_t t);
        halt = t.halt; jump = t.jump; beqz = t.beqz; bnez = t.bnez;
        bgez = t.bgez; bltz = t.bltz; sel_pc_opA = t.opa; sel_pc_opB = t.opb;
        rs_data = t.rs;
    endtask

    // Entered just after a rising edge; holds rst for n cycles, then releases it
    // and leaves the bench in the first post-reset cycle.
    task automatic apply_reset(input int n, input logic rdy, input logic rdy2);
        rst = 1'b1;
        bus.imem_rdy    = rdy;
        bus.instr_ready = rdy2;
        bus.imem_rdata  = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_imem_req", 16'(bus.imem_req), 16'd0);
            check("rst_instr_valid", 16'(bus.instr_valid), 16'd0);
            check("rst_halted", 16'(halted), 16'd0);
            @(posedge clk); #2;
        end
        rst = 1'b0;
        bus.imem_rdy    = 1'b0;
        bus.instr_ready = 1'b0;
        fetch_q.delete();
        issue_q.delete();
        model_pc = RESET_PC;
        #1;
        check("post_rst_req", 16'(bus.imem_req), 16'd1);
        check("post_rst_addr", bus.imem_addr, RESET_PC);
        check("post_rst_halted", 16'(halted), 16'd0);
    endtask

    // One fetch + issue transaction; updates the model when it commits.
    task automatic run_txn(input txn_t t);
        int  cnt;
        int  total;
        bit  fired;
        fetch_q.push_back(model_pc);
        cnt = 0; fired = 0;
        while (!fired && cnt < 64) begin
            drive_random_flags();
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.imem_rdata  = t.word;
            if (t.abort == 1 && cnt == t.wf) begin
                apply_reset(1, 1'b1, 1'b1);
                return;
            end
            bus.imem_rdy = (cnt >= t.wf);
            #1;
            fired = bus.imem_req && bus.imem_rdy;
            @(posedge clk); #2;
            cnt++;
        end
        if (!fired) begin
            fail_now("fetch_timeout");
            return;
        end
        total = cnt;

        if (t.abort != 2) issue_q.push_back('{t.word, model_pc + 16'd2});
        cnt = 0; fired = 0;
        while (!fired && cnt < 64) begin
            drive_flags(t);
            bus.imem_rdy   = 1'($urandom_range(0, 1));
            bus.imem_rdata = 16'($urandom);
            if (t.abort == 2 && cnt == t.wi) begin
                apply_reset(1, 1'($urandom_range(0, 1)), 1'b1);
                return;
            end
            bus.instr_ready = (cnt >= t.wi);
            #1;
            fired = bus.instr_valid && bus.instr_ready;
            @(posedge clk); #2;
            cnt++;
        end
        if (!fired) begin
            fail_now("issue_timeout");
            return;
        end
        total += cnt;
        check("latency", 16'(total), 16'(t.wf + t.wi + 2));
        if (!t.halt) model_pc = model_next(model_pc, t);
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        issue_exp_t e;
        if (!rst) begin
            if (bus.imem_req && fetch_q.size() > 0)
                check("fetch_addr", bus.imem_addr, fetch_q[0]);
            if (bus.imem_req && bus.imem_rdy) begin
                if (fetch_q.size() == 0) fail_now("unexpected_fetch");
                else void'(fetch_q.pop_front());
            end
            if (bus.instr_valid && issue_q.size() > 0) begin
                check("instr_held", bus.instr, issue_q[0].instr);
                check("pc_plus2", bus.pc_plus2, issue_q[0].pc_plus2);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (issue_q.size() == 0) begin
                    fail_now("unexpected_issue");
                end else begin
                    e = issue_q.pop_front();
                    check("opcode", 16'(bus.opcode), 16'(int'(e.instr) / 2048));
                    check("op_ext", 16'(bus.op_ext), 16'(int'(e.instr) % 4));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        rst = 1'b1;
        bus.imem_rdy = 1'b0; bus.instr_ready = 1'b0; bus.imem_rdata = 16'h0000;
        drive_random_flags();
        model_pc = RESET_PC;
        @(posedge clk); #2;
        apply_reset(2, 1'b0, 1'b0);

        // Straight-line fetch 0000, 0002, 0004 with two cycles each.
        for (int i = 0; i < 3; i++) run_txn(plain_txn());

        // Memory stall of three cycles at 0x0010.
        run_txn(jump_txn(16'h0010));
        t = plain_txn(); t.wf = 3; run_txn(t);

        // beqz, short offset 0xFC from 0x0020: taken -> 0x001E, not taken -> 0x0022.
        run_txn(jump_txn(16'h0020));
        t = plain_txn(); t.word = 16'hA5FC; t.beqz = 1; t.opb = 1; t.rs = 16'h0000;
        run_txn(t);
        run_txn(jump_txn(16'h0020));
        t.rs = 16'h0001;
        run_txn(t);
        run_txn(plain_txn());

        // Register jump to 0x1234, then wrap from 0xFFFE to 0x0000.
        run_txn(jump_txn(16'h1234));
        run_txn(jump_txn(16'hFFFE));
        run_txn(plain_txn());
        run_txn(plain_txn());

        // Conflicting flags: beqz and bnez together always branch.
        t = plain_txn(); t.beqz = 1; t.bnez = 1; t.rs = 16'($urandom);
        run_txn(t);
        run_txn(plain_txn());

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            t = plain_txn();
            t.jump = ($urandom_range(0, 5) == 0);
            t.beqz = ($urandom_range(0, 5) == 0);
            t.bnez = ($urandom_range(0, 5) == 0);
            t.bgez = ($urandom_range(0, 5) == 0);
            t.bltz = ($urandom_range(0, 5) == 0);
            t.opa  = 1'($urandom_range(0, 1));
            t.opb  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       t.rs = 16'h0000;
                1:       t.rs = 16'h8000 | 16'($urandom);
                default: t.rs = 16'($urandom);
            endcase
            t.wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            t.wi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_txn(t);
        end

        // Halt accepted after two cycles of back-pressure; stays halted.
        t = plain_txn(); t.halt = 1; t.jump = 1; t.wi = 2;
        run_txn(t);
        for (int i = 0; i < 4; i++) begin
            bus.imem_rdy    = 1'($urandom_range(0, 1));
            bus.instr_ready = 1'($urandom_range(0, 1));
            drive_random_flags();
            #1;
            check("halted", 16'(halted), 16'd1);
            check("halt_imem_req", 16'(bus.imem_req), 16'd0);
            check("halt_instr_valid", 16'(bus.instr_valid), 16'd0);
            @(posedge clk); #2;
        end
        apply_reset(1, 1'b1, 1'b1);
        run_txn(plain_txn());

        // Reset during issue with instr_ready high: the jump must not commit.
        t = jump_txn(16'h4444); t.wi = 1; t.abort = 2;
        run_txn(t);
        run_txn(plain_txn());

        // Reset during fetch with imem_rdy high: the fetch is abandoned.
        run_txn(plain_txn());
        t = plain_txn(); t.wf = 2; t.abort = 1;
        run_txn(t);
        run_txn(plain_txn());
        run_txn(plain_txn());

        if (fetch_q.size() > 1) fail_now("fetch_q_leftover");
        if (issue_q.size() != 0) fail_now("issue_q_leftover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
